// File: rtl/ifu_miss_handler.sv
// ifu_miss_handler: collects instruction-cache line misses into a small
// de-duplicating FIFO, issues one memory read per distinct tag, assembles the
// returned beats into a full line and hands tag plus line back to the cache.
module ifu_miss_handler #(
    parameter int TAG_WIDTH      = 27,
    parameter int LINE_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 32,
    parameter int OFFSET_WIDTH   = 5,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic                           Clock,
    input  logic                           Rst,
    input  logic [TAG_WIDTH-1:0]           cache_reqTagIn,
    input  logic                           cache_reqTagValidIn,
    output logic                           cache_reqReadyOut,
    output logic [TAG_WIDTH-1:0]           cache_rspTagOut,
    output logic [LINE_WIDTH-1:0]          cache_rspInsLineOut,
    output logic                           cache_rspInsLineValidOut,
    output logic [ADDR_WIDTH-1:0]          mem_reqAddrOut,
    output logic                           mem_reqValidOut,
    input  logic                           mem_reqReadyIn,
    input  logic [MEM_DATA_WIDTH-1:0]      mem_rspDataIn,
    input  logic                           mem_rspValidIn,
    output logic [$clog2(QUEUE_DEPTH):0]   pendingCountOut
);

    localparam int BEATS  = LINE_WIDTH / MEM_DATA_WIDTH;
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_RSP
    } state_e;

    state_e                   state_q;
    logic [TAG_WIDTH-1:0]     fifo_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic [BEAT_W-1:0]        beat_q;
    logic [LINE_WIDTH-1:0]    line_q;
    logic                     mem_req_valid_q;
    logic [ADDR_WIDTH-1:0]    mem_req_addr_q;
    logic                     rsp_valid_q;
    logic [TAG_WIDTH-1:0]     rsp_tag_q;
    logic [LINE_WIDTH-1:0]    rsp_line_q;

    logic                     full;
    logic                     accept;
    logic                     dup;
    logic                     push;
    logic                     pop;
    logic                     last_beat;
    logic [TAG_WIDTH-1:0]     head_tag;
    logic [QUEUE_DEPTH-1:0]   entry_valid;
    logic [LINE_WIDTH-1:0]    line_d;

    // Ready comes from registered occupancy only, so a pop in the same cycle
    // never makes room for that cycle's push.
    assign full      = (count_q == CNT_W'(QUEUE_DEPTH));
    assign accept    = cache_reqTagValidIn && !full;
    assign push      = accept && !dup;
    assign pop       = (state_q == S_RSP);
    assign head_tag  = fifo_q[rd_ptr_q];
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    // Flag an incoming tag that already sits anywhere in the queue, head included.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        entry_valid = '0;
        dup         = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            entry_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
            if (entry_valid[i] && (fifo_q[i] == cache_reqTagIn)) begin
                dup = 1'b1;
            end
        end
    end

    // Current line with the incoming beat merged into its slot.
    always_comb begin
        line_d = line_q;
        line_d[beat_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rspDataIn;
    end

    // Queue pointers and occupancy; the head is popped only when its line returns.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (Rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Tag storage written at the tail.
    always_ff @(posedge Clock) begin
        // NOTE: storage is deliberately not reset; the reset pointers and count
        // mark every entry invalid, so stale contents are never observed.
        if (push) begin
            fifo_q[wr_ptr_q] <= cache_reqTagIn;
        end
    end

    // Miss-processing FSM with registered memory-request and response outputs.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q         <= S_IDLE;
            beat_q          <= '0;
            line_q          <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_tag_q       <= '0;
            rsp_line_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q         <= S_REQ;
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= {head_tag, OFFSET_WIDTH'(0)};
                    end
                end
                S_REQ: begin
                    if (mem_reqReadyIn) begin
                        state_q         <= S_DATA;
                        mem_req_valid_q <= 1'b0;
                        beat_q          <= '0;
                    end
                end
                S_DATA: begin
                    if (mem_rspValidIn) begin
                        line_q <= line_d;
                        beat_q <= beat_q + BEAT_W'(1);
                        if (last_beat) begin
                            state_q     <= S_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_tag_q   <= head_tag;
                            rsp_line_q  <= line_d;
                        end
                    end
                end
                S_RSP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cache_reqReadyOut        = !full;
    assign cache_rspTagOut          = rsp_tag_q;
    assign cache_rspInsLineOut      = rsp_line_q;
    assign cache_rspInsLineValidOut = rsp_valid_q;
    assign mem_reqAddrOut           = mem_req_addr_q;
    assign mem_reqValidOut          = mem_req_valid_q;
    assign pendingCountOut          = count_q;

endmodule

// File: tb/tb_ifu_miss_handler.sv
// tb_ifu_miss_handler: directed stimulus for the miss handler with a
// transaction-level model (pending-tag queue plus miss phase) compared against
// the DUT on every negative clock edge, plus hand-computed literal checks.
module tb_ifu_miss_handler;

    localparam int TW = 27;
    localparam int LW = 128;
    localparam int QD = 4;

    logic           Clock = 1'b0;
    logic           Rst = 1'b1;
    logic [TW-1:0]  cache_reqTagIn = '0;
    logic           cache_reqTagValidIn = 1'b0;
    logic           cache_reqReadyOut;
    logic [TW-1:0]  cache_rspTagOut;
    logic [LW-1:0]  cache_rspInsLineOut;
    logic           cache_rspInsLineValidOut;
    logic [31:0]    mem_reqAddrOut;
    logic           mem_reqValidOut;
    logic           mem_reqReadyIn = 1'b0;
    logic [31:0]    mem_rspDataIn = '0;
    logic           mem_rspValidIn = 1'b0;
    logic [2:0]     pendingCountOut;

    int n_checks = 0;
    int n_fail   = 0;
    int n_mem_req = 0;
    int n_rsp     = 0;

    ifu_miss_handler dut (
        .Clock                    (Clock),
        .Rst                      (Rst),
        .cache_reqTagIn           (cache_reqTagIn),
        .cache_reqTagValidIn      (cache_reqTagValidIn),
        .cache_reqReadyOut        (cache_reqReadyOut),
        .cache_rspTagOut          (cache_rspTagOut),
        .cache_rspInsLineOut      (cache_rspInsLineOut),
        .cache_rspInsLineValidOut (cache_rspInsLineValidOut),
        .mem_reqAddrOut           (mem_reqAddrOut),
        .mem_reqValidOut          (mem_reqValidOut),
        .mem_reqReadyIn           (mem_reqReadyIn),
        .mem_rspDataIn            (mem_rspDataIn),
        .mem_rspValidIn           (mem_rspValidIn),
        .pendingCountOut          (pendingCountOut)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {PH_IDLE, PH_REQ, PH_DATA, PH_RSP} phase_e;

    logic [TW-1:0]  m_q[$];
    phase_e         m_phase = PH_IDLE;
    int             m_k = 0;
    logic [LW-1:0]  m_line = '0;
    bit             m_live = 1'b0;
    bit             m_acc;
    bit             m_dup;

    // Compare the DUT against the model, then advance the model with this
    // cycle's inputs (which the DUT samples at the next rising edge).
    always @(negedge Clock) begin
        if (m_live) begin
            check("ready", cache_reqReadyOut, (m_q.size() < QD));
            check("pending", pendingCountOut, m_q.size());
            check("mem_valid", mem_reqValidOut, (m_phase == PH_REQ));
            if (m_phase == PH_REQ) check("mem_addr", mem_reqAddrOut, {m_q[0], 5'b0});
            check("rsp_valid", cache_rspInsLineValidOut, (m_phase == PH_RSP));
            if (m_phase == PH_RSP) begin
                check("rsp_tag", cache_rspTagOut, m_q[0]);
                check("rsp_line", cache_rspInsLineOut, m_line);
            end
            if (!Rst && mem_reqValidOut && mem_reqReadyIn) n_mem_req++;
            if (cache_rspInsLineValidOut) n_rsp++;
        end
        if (Rst) begin
            m_q.delete();
            m_phase = PH_IDLE;
            m_k     = 0;
            m_line  = '0;
            m_live  = 1'b1;
        end else if (m_live) begin
            m_acc = cache_reqTagValidIn && (m_q.size() < QD);
            m_dup = 1'b0;
            foreach (m_q[i]) if (m_q[i] == cache_reqTagIn) m_dup = 1'b1;
            case (m_phase)
                PH_IDLE: if (m_q.size() > 0) m_phase = PH_REQ;
                PH_REQ: if (mem_reqReadyIn) begin
                    m_phase = PH_DATA;
                    m_k = 0;
                end
                PH_DATA: if (mem_rspValidIn) begin
                    m_line[m_k*32 +: 32] = mem_rspDataIn;
                    m_k++;
                    if (m_k == LW / 32) m_phase = PH_RSP;
                end
                PH_RSP: begin
                    void'(m_q.pop_front());
                    m_phase = PH_IDLE;
                end
                default: m_phase = PH_IDLE;
            endcase
            if (m_acc && !m_dup) m_q.push_back(cache_reqTagIn);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_tag(input logic [TW-1:0] tag);
        cache_reqTagIn = tag;
        cache_reqTagValidIn = 1'b1;
        tick();
        cache_reqTagValidIn = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (mem_reqValidOut !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("wait_req_timeout", mem_reqValidOut, 1'b1);
    endtask

    task automatic grant();
        mem_reqReadyIn = 1'b1;
        tick();
        mem_reqReadyIn = 1'b0;
    endtask

    // Drive four beats with 'gap' idle cycles between them; returns in the RSP cycle.
    task automatic send_line(input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input logic [31:0] b3, input int gap);
        logic [31:0] bs [4];
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        for (int k = 0; k < 4; k++) begin
            mem_rspDataIn  = bs[k];
            mem_rspValidIn = 1'b1;
            tick();
            mem_rspValidIn = 1'b0;
            if (k < 3) repeat (gap) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_req;
        int base_rsp;

        // Reset
        Rst = 1'b1;
        tick(); tick();
        Rst = 1'b0;
        check("reset_ready", cache_reqReadyOut, 1'b1);
        check("reset_pending", pendingCountOut, 3'd0);
        check("reset_mem_valid", mem_reqValidOut, 1'b0);
        check("reset_mem_addr", mem_reqAddrOut, 32'h0);
        check("reset_rsp_valid", cache_rspInsLineValidOut, 1'b0);
        check("reset_rsp_tag", cache_rspTagOut, 27'h0);
        check("reset_rsp_line", cache_rspInsLineOut, 128'h0);
        tick();

        // Single miss
        push_tag(27'h0000001);
        check("single_pending", pendingCountOut, 3'd1);
        check("single_not_yet_valid", mem_reqValidOut, 1'b0);
        tick();
        check("single_req_valid", mem_reqValidOut, 1'b1);
        check("single_req_addr", mem_reqAddrOut, 32'h00000020);
        tick();
        check("single_req_held", mem_reqAddrOut, 32'h00000020);
        grant();
        send_line(32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333, 0);
        check("single_rsp_valid", cache_rspInsLineValidOut, 1'b1);
        check("single_rsp_tag", cache_rspTagOut, 27'h1);
        check("single_rsp_line", cache_rspInsLineOut, 128'h333333332222222211111111DEADBEEF);
        tick();
        check("single_rsp_pulse_end", cache_rspInsLineValidOut, 1'b0);
        check("single_drained", pendingCountOut, 3'd0);

        // Dedup
        base_req = n_mem_req;
        base_rsp = n_rsp;
        push_tag(27'h2);
        wait_req(5);
        push_tag(27'h2);
        check("dedup_pending", pendingCountOut, 3'd1);
        grant();
        send_line(32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003, 0);
        repeat (4) tick();
        check("dedup_one_req", n_mem_req - base_req, 1);
        check("dedup_one_rsp", n_rsp - base_rsp, 1);
        check("dedup_idle", mem_reqValidOut, 1'b0);

        // Full queue, in-order drain
        push_tag(27'h10);
        push_tag(27'h11);
        push_tag(27'h12);
        push_tag(27'h13);
        check("full_ready", cache_reqReadyOut, 1'b0);
        check("full_pending", pendingCountOut, 3'd4);
        push_tag(27'h14);
        check("full_reject", pendingCountOut, 3'd4);
        for (int i = 0; i < 4; i++) begin
            logic [26:0] t;
            t = 27'h10 + 27'(i);
            wait_req(10);
            check("full_addr", mem_reqAddrOut, {t, 5'b0});
            grant();
            send_line(32'hB0000000 + 32'(i), 32'hB1000000, 32'hB2000000, 32'hB3000000 + 32'(i), 0);
            check("full_rsp_tag", cache_rspTagOut, t);
            tick();
            if (i == 0) begin
                check("full_ready_back", cache_reqReadyOut, 1'b1);
                check("full_pending_3", pendingCountOut, 3'd3);
            end
        end
        tick();

        // Stray beats and beat gaps
        mem_rspDataIn  = 32'hBAD0BAD0;
        mem_rspValidIn = 1'b1;
        tick();
        mem_rspValidIn = 1'b0;
        push_tag(27'h3);
        wait_req(5);
        mem_rspDataIn  = 32'hBAD0BAD0;
        mem_rspValidIn = 1'b1;
        tick();
        mem_rspValidIn = 1'b0;
        grant();
        send_line(32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777, 2);
        check("gap_rsp_valid", cache_rspInsLineValidOut, 1'b1);
        check("gap_rsp_line", cache_rspInsLineOut, 128'h77777777666666665555555544444444);
        tick(); tick();

        // Reset in the middle of DATA
        base_rsp = n_rsp;
        push_tag(27'h4);
        wait_req(5);
        grant();
        for (int k = 0; k < 2; k++) begin
            mem_rspDataIn  = 32'hC0C0C000 + 32'(k);
            mem_rspValidIn = 1'b1;
            tick();
            mem_rspValidIn = 1'b0;
        end
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("rst_pending", pendingCountOut, 3'd0);
        check("rst_ready", cache_reqReadyOut, 1'b1);
        check("rst_mem_valid", mem_reqValidOut, 1'b0);
        repeat (6) tick();
        check("rst_no_rsp", n_rsp - base_rsp, 0);
        push_tag(27'h5);
        wait_req(5);
        check("rst_fresh_addr", mem_reqAddrOut, 32'h000000A0);
        grant();
        send_line(32'h00000005, 32'h00000050, 32'h00000500, 32'h00005000, 1);
        check("rst_fresh_tag", cache_rspTagOut, 27'h5);
        check("rst_fresh_line", cache_rspInsLineOut, 128'h00005000000005000000005000000005);
        tick(); tick();

        // Push during RSP: new tag queued, head tag dropped
        push_tag(27'h6);
        wait_req(5);
        grant();
        send_line(32'h60, 32'h61, 32'h62, 32'h63, 0);
        check("rsp6_valid", cache_rspInsLineValidOut, 1'b1);
        push_tag(27'h7);
        check("rsp7_pending", pendingCountOut, 3'd1);
        check("rsp7_not_yet", mem_reqValidOut, 1'b0);
        tick();
        check("rsp7_req_valid", mem_reqValidOut, 1'b1);
        check("rsp7_req_addr", mem_reqAddrOut, 32'h000000E0);
        grant();
        send_line(32'h70, 32'h71, 32'h72, 32'h73, 0);
        check("rsp7_tag", cache_rspTagOut, 27'h7);
        tick(); tick();
        push_tag(27'h6);
        wait_req(5);
        grant();
        send_line(32'h64, 32'h65, 32'h66, 32'h67, 0);
        check("rsp6b_valid", cache_rspInsLineValidOut, 1'b1);
        push_tag(27'h6);
        check("rsp6b_dropped", pendingCountOut, 3'd0);
        tick(); tick();
        check("rsp6b_no_req", mem_reqValidOut, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
